branch_redirect_unit: RTL and testbench
=======================================

// Module: branch_redirect_unit
// PURPOSE
//  Execute-stage control-flow resolver; the producing end of the fetch redirect interface.
//  Drives PCSrcE/PCTargetE (taken branch, jump, call) and PCReturnSignalE/PCReturnE (return).
//  Holds a circular return-address stack (RAS) and emits D/E flush on every redirect.
//  Sits between the execute datapath (target calc, condition flags) and the fetch stage.
// PARAMETERS
//  PC_W       9   PC width; instruction-word addressed (next sequential PC = PC + 1)
//  RAS_DEPTH  8   return-address stack entries; power of two, >= 2
//  CNT_W      16  width of the saturating redirect counter
// PORTS
//  clk              in   1          clock, rising edge
//  rst              in   1          async reset, active-low
//  ValidE           in   1          E-stage holds a real (non-bubble) instruction
//  StallE           in   1          E-stage stalled this cycle
//  BranchE          in   1          conditional branch
//  JumpE            in   1          unconditional jump
//  CallE            in   1          call: jump + push return address
//  ReturnE          in   1          return: pop RAS, redirect to popped address
//  CondTakenE       in   1          branch condition evaluated true
//  TargetE          in   PC_W       computed branch/jump/call target
//  PCPlus4E         in   PC_W       sequential PC of the E-stage instruction
//  PCSrcE           out  1          redirect fetch to PCTargetE
//  PCTargetE        out  PC_W       redirect target
//  PCReturnSignalE  out  1          redirect fetch to PCReturnE (fetch gives it priority)
//  PCReturnE        out  PC_W       popped return address
//  FlushD           out  1          squash D-stage register
//  FlushE           out  1          squash E-stage register
//  RasOverflow      out  1          sticky: a push hit a full stack
//  RasUnderflow     out  1          sticky: a return hit an empty stack
//  RedirectCount    out  CNT_W      saturating count of redirects
// BEHAVIOUR
//  act = ValidE & ~StallE. All redirect/flush outputs combinational, same cycle as inputs.
//  PCSrcE = act & ~ReturnE & (JumpE | CallE | (BranchE & CondTakenE)); PCTargetE = TargetE.
//  PCReturnSignalE = act & ReturnE & (count != 0); PCReturnE = top entry, 0 if count == 0.
//  FlushD = FlushE = PCSrcE | PCReturnSignalE.
//  RAS state: entries[RAS_DEPTH], ptr (log2 DEPTH bits, next free slot, wraps), count (0..DEPTH).
//  Updates on rising clk only when act:
//   call only, count<DEPTH : entries[ptr]<=PCPlus4E, ptr+1, count+1.
//   call only, full        : overwrite oldest (same slot), ptr+1, count stays DEPTH, RasOverflow<=1.
//   return only, count>0   : ptr-1, count-1 (entry contents untouched).
//   return only, empty     : no redirect, no pointer change, RasUnderflow<=1.
//   call+return, count>0   : redirect to old top; top slot replaced by PCPlus4E; ptr/count unchanged.
//   call+return, empty     : no redirect; push PCPlus4E as a normal call; RasUnderflow<=1.
//   BranchE/JumpE with CallE/ReturnE: CallE/ReturnE rules win; BranchE ignored.
//  ~act (bubble or stall): no outputs asserted, no state change, counters held.
//  RedirectCount += 1 on each cycle with FlushD; saturates at all-ones, no wrap.
//  Sticky flags clear only on reset.
//  Reset (rst=0, async): ptr=0, count=0, all entries=0, flags=0, RedirectCount=0;
//   outputs combinational, so all redirect/flush outputs read 0 while inputs are idle.
//   Reset mid-call/return discards the update; stack is empty after release.
// TESTING
//  1 reset; BranchE=1,CondTakenE=1,TargetE=0x040,act -> PCSrcE=1,PCTargetE=0x040,FlushD/E=1,count=1.
//  2 CallE,TargetE=0x080,PCPlus4E=0x011; then ReturnE -> PCReturnSignalE=1,PCReturnE=0x011,RAS empty.
//  3 9 calls (PCPlus4E=1..9), DEPTH=8 -> RasOverflow=1; 8 returns yield 9,8..2; 9th: no redirect, RasUnderflow=1.
//  4 ValidE=1,StallE=1 with CallE -> no PCSrcE, no push; deassert StallE -> push+redirect once.
//  5 CallE+ReturnE, top=0x020, PCPlus4E=0x031 -> PCReturnE=0x020, next return yields 0x031.
//  6 force RedirectCount to 0xFFFF, one taken branch -> stays 0xFFFF; pulse rst mid-push -> stack empty.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit
//
// Execute-stage control-flow resolver and the producing end of the fetch
// redirect interface. It resolves taken branches, jumps and calls into a
// PCSrcE/PCTargetE redirect. It resolves returns into a
// PCReturnSignalE/PCReturnE redirect, which it pops from a circular
// return-address stack (RAS). Any redirect also raises D/E flush.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active-low
//   ValidE           E-stage holds a real instruction (not a bubble)
//   StallE           E-stage is stalled this cycle
//   BranchE          conditional branch
//   JumpE            unconditional jump
//   CallE            call: jump and push the return address
//   ReturnE          return: pop the RAS and redirect to the popped address
//   CondTakenE       branch condition evaluated true
//   TargetE          computed branch/jump/call target
//   PCPlus4E         sequential PC of the E-stage instruction
//   PCSrcE           redirect fetch to PCTargetE
//   PCTargetE        redirect target
//   PCReturnSignalE  redirect fetch to PCReturnE (fetch gives it priority)
//   PCReturnE        top-of-stack return address, 0 when the stack is empty
//   FlushD, FlushE   squash the D and E stage registers
//   RasOverflow      sticky: a push found the stack full
//   RasUnderflow     sticky: a return found the stack empty
//   RedirectCount    saturating count of redirect cycles
// ---------------------------------------------------------------------------
module branch_redirect_unit #(
    parameter int PC_W      = 9,
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             CallE,
    input  logic             ReturnE,
    input  logic             CondTakenE,
    input  logic [PC_W-1:0]  TargetE,
    input  logic [PC_W-1:0]  PCPlus4E,
    output logic             PCSrcE,
    output logic [PC_W-1:0]  PCTargetE,
    output logic             PCReturnSignalE,
    output logic [PC_W-1:0]  PCReturnE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             RasOverflow,
    output logic             RasUnderflow,
    output logic [CNT_W-1:0] RedirectCount
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    // ptr is the next free slot and wraps modulo RAS_DEPTH. count says how
    // many slots hold live entries, so a full stack and an empty stack can
    // be told apart even though ptr is the same in both.
    logic [PC_W-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] top_idx;
    logic             act;
    logic             empty;
    logic             full;
    logic             redirect;

    assign act     = ValidE & ~StallE;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign top_idx = ptr - 1'b1;

    // NOTE: every output gets a default before any condition is tested, so
    // no path through the block leaves an output unassigned and no latch is
    // inferred.
    always_comb begin
        PCSrcE          = 1'b0;
        PCTargetE       = TargetE;
        PCReturnSignalE = 1'b0;
        PCReturnE       = '0;
        if (!empty) begin
            PCReturnE = entries[top_idx];
        end
        if (act) begin
            // When a call or return is present, those rules decide and the
            // branch is ignored. A return suppresses PCSrcE even when it is
            // paired with a call.
            PCSrcE          = ~ReturnE & (JumpE | CallE | (BranchE & CondTakenE));
            PCReturnSignalE = ReturnE & ~empty;
        end
    end

    assign redirect = PCSrcE | PCReturnSignalE;
    assign FlushD   = redirect;
    assign FlushE   = redirect;

    // NOTE: the return stack is a plain register array. It is cleared on
    // reset so that PCReturnE and later pops read defined values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= '0;
            end
            ptr          <= '0;
            count        <= '0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else if (act) begin
            // NOTE: state updates use non-blocking assignments. Every read
            // in this block then sees the pre-edge values of ptr and count.
            if (CallE && ReturnE) begin
                if (!empty) begin
                    // The old top was already sent to fetch this cycle. The
                    // call's return address takes its slot.
                    entries[top_idx] <= PCPlus4E;
                end else begin
                    entries[ptr] <= PCPlus4E;
                    ptr          <= ptr + 1'b1;
                    count        <= count + 1'b1;
                    RasUnderflow <= 1'b1;
                end
            end else if (CallE) begin
                // On a full stack the write lands on the oldest entry,
                // because the slot after the top wraps onto it.
                entries[ptr] <= PCPlus4E;
                ptr          <= ptr + 1'b1;
                if (full) begin
                    RasOverflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (ReturnE) begin
                if (!empty) begin
                    ptr   <= ptr - 1'b1;
                    count <= count - 1'b1;
                end else begin
                    RasUnderflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RedirectCount <= '0;
        end else if (redirect && !(&RedirectCount)) begin
            RedirectCount <= RedirectCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_unit
//
// Self-checking bench for branch_redirect_unit. The model keeps the return
// stack as a queue, bounded to RAS_DEPTH by dropping the oldest entry. A
// compare process checks every output on each falling edge. Directed
// scenarios add literal expectations, then a randomized phase follows. A
// second instance with a 4-bit counter makes counter saturation reachable in
// a short run.
// ---------------------------------------------------------------------------
module tb_branch_redirect_unit;

    localparam int PC_W  = 9;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int SAT_W = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ValidE, StallE, BranchE, JumpE, CallE, ReturnE, CondTakenE;
    logic [PC_W-1:0]  TargetE, PCPlus4E;
    logic             PCSrcE, PCReturnSignalE, FlushD, FlushE;
    logic [PC_W-1:0]  PCTargetE, PCReturnE;
    logic             RasOverflow, RasUnderflow;
    logic [CNT_W-1:0] RedirectCount;

    logic             s_src, s_rsig, s_fd, s_fe, s_ovf, s_udf;
    logic [PC_W-1:0]  s_tgt, s_ret;
    logic [SAT_W-1:0] s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect_unit #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .StallE(StallE), .BranchE(BranchE),
        .JumpE(JumpE), .CallE(CallE), .ReturnE(ReturnE), .CondTakenE(CondTakenE),
        .TargetE(TargetE), .PCPlus4E(PCPlus4E), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .PCReturnSignalE(PCReturnSignalE), .PCReturnE(PCReturnE), .FlushD(FlushD),
        .FlushE(FlushE), .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow),
        .RedirectCount(RedirectCount)
    );

    branch_redirect_unit #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .ValidE(ValidE), .StallE(StallE), .BranchE(BranchE),
        .JumpE(JumpE), .CallE(CallE), .ReturnE(ReturnE), .CondTakenE(CondTakenE),
        .TargetE(TargetE), .PCPlus4E(PCPlus4E), .PCSrcE(s_src), .PCTargetE(s_tgt),
        .PCReturnSignalE(s_rsig), .PCReturnE(s_ret), .FlushD(s_fd), .FlushE(s_fe),
        .RasOverflow(s_ovf), .RasUnderflow(s_udf), .RedirectCount(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PC_W-1:0] stk[$];
    bit m_ovf = 0, m_udf = 0;
    int m_cnt = 0;

    function automatic bit m_act();
        return ValidE && !StallE;
    endfunction

    function automatic bit m_src();
        return m_act() && !ReturnE && (JumpE || CallE || (BranchE && CondTakenE));
    endfunction

    function automatic bit m_rsig();
        return m_act() && ReturnE && stk.size() > 0;
    endfunction

    always @(negedge rst) begin
        stk.delete();
        m_ovf = 0;
        m_udf = 0;
        m_cnt = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (m_src() || m_rsig()) m_cnt++;
            if (m_act()) begin
                if (CallE && ReturnE) begin
                    if (stk.size() > 0) stk[stk.size()-1] = PCPlus4E;
                    else begin
                        stk.push_back(PCPlus4E);
                        m_udf = 1;
                    end
                end else if (CallE) begin
                    stk.push_back(PCPlus4E);
                    if (stk.size() > DEPTH) begin
                        void'(stk.pop_front());
                        m_ovf = 1;
                    end
                end else if (ReturnE) begin
                    if (stk.size() > 0) void'(stk.pop_back());
                    else m_udf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_red;
        e_red = m_src() || m_rsig();
        check("PCSrcE", 32'(PCSrcE), 32'(m_src()));
        if (m_src()) check("PCTargetE", 32'(PCTargetE), 32'(TargetE));
        check("PCReturnSignalE", 32'(PCReturnSignalE), 32'(m_rsig()));
        check("PCReturnE", 32'(PCReturnE), (stk.size() > 0) ? 32'(stk[stk.size()-1]) : 32'd0);
        check("FlushD", 32'(FlushD), 32'(e_red));
        check("FlushE", 32'(FlushE), 32'(e_red));
        check("RasOverflow", 32'(RasOverflow), 32'(m_ovf));
        check("RasUnderflow", 32'(RasUnderflow), 32'(m_udf));
        check("RedirectCount", 32'(RedirectCount), 32'((m_cnt > CNT_MAX) ? CNT_MAX : m_cnt));
        check("SatRedirectCount", 32'(s_cnt), 32'((m_cnt > SAT_MAX) ? SAT_MAX : m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit st, input bit br, input bit jp, input bit ca,
                         input bit rt, input bit cd, input int tgt, input int pc4);
        ValidE = v; StallE = st; BranchE = br; JumpE = jp; CallE = ca; ReturnE = rt;
        CondTakenE = cd; TargetE = PC_W'(tgt); PCPlus4E = PC_W'(pc4);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_PCSrcE", 32'(PCSrcE), 32'd0);
        check("rst_PCReturnSignalE", 32'(PCReturnSignalE), 32'd0);
        check("rst_count", 32'(RedirectCount), 32'd0);
        check("rst_flags", {30'd0, RasOverflow, RasUnderflow}, 32'd0);
        rst = 1'b1;
        step();

        // 1: taken branch
        drive(1, 0, 1, 0, 0, 0, 1, 'h040, 'h005);
        #2;
        check("t1_PCSrcE", 32'(PCSrcE), 32'd1);
        check("t1_PCTargetE", 32'(PCTargetE), 32'h040);
        check("t1_flush", {30'd0, FlushD, FlushE}, 32'd3);
        step();
        idle();
        #2;
        check("t1_count", 32'(RedirectCount), 32'd1);

        // 2: call then return
        drive(1, 0, 0, 0, 1, 0, 0, 'h080, 'h011);
        step();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("t2_rsig", 32'(PCReturnSignalE), 32'd1);
        check("t2_ret", 32'(PCReturnE), 32'h011);
        step();
        idle();
        #2;
        check("t2_empty", 32'(PCReturnE), 32'd0);

        // 3: overflow and underflow
        for (int i = 1; i <= 9; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 'h100, i);
            step();
        end
        idle();
        #2;
        check("t3_ovf", 32'(RasOverflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
            #2;
            check("t3_pop", 32'(PCReturnE), 32'(9 - i));
            step();
        end
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("t3_no_redirect", 32'(PCReturnSignalE), 32'd0);
        step();
        idle();
        #2;
        check("t3_udf", 32'(RasUnderflow), 32'd1);

        // 4: stalled call has no effect until the stall lifts
        drive(1, 1, 0, 0, 1, 0, 0, 'h0A0, 'h055);
        #2;
        check("t4_stall_src", 32'(PCSrcE), 32'd0);
        step();
        #2;
        check("t4_no_push", 32'(PCReturnE), 32'd0);
        StallE = 1'b0;
        #1;
        check("t4_src", 32'(PCSrcE), 32'd1);
        step();
        idle();
        #2;
        check("t4_pushed", 32'(PCReturnE), 32'h055);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step();

        // 5: call+return swaps the top entry
        drive(1, 0, 0, 0, 1, 0, 0, 'h0C0, 'h020);
        step();
        drive(1, 0, 0, 0, 1, 1, 0, 'h0C8, 'h031);
        #2;
        check("t5_ret", 32'(PCReturnE), 32'h020);
        check("t5_rsig", 32'(PCReturnSignalE), 32'd1);
        check("t5_src", 32'(PCSrcE), 32'd0);
        step();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("t5_next", 32'(PCReturnE), 32'h031);
        step();

        // 6: reset during a push discards it
        drive(1, 0, 0, 0, 1, 0, 0, 'h0E0, 'h077);
        step();
        drive(1, 0, 0, 0, 1, 0, 0, 'h0E0, 'h078);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        #2;
        check("t6_empty", 32'(PCReturnE), 32'd0);
        check("t6_count", 32'(RedirectCount), 32'd0);
        check("t6_flags", {30'd0, RasOverflow, RasUnderflow}, 32'd0);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        check("t6_no_ret", 32'(PCReturnSignalE), 32'd0);
        step();

        // randomized phase
        for (int n = 0; n < 500; n++) begin
            drive(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
                  ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                  $urandom % 2, int'($urandom % 512), int'($urandom % 512));
            step();
        end
        idle();
        #2;
        check("sat_count", 32'(s_cnt), 32'(SAT_MAX));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
